mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the BamBoo RV32I pipeline, directly downstream of the execute stage. Takes the ALU result (effective address or plain result), store data and decoded load/store controls. For loads/stores it runs a single-outstanding request/grant/rvalid transaction on the data-memory port, generates byte enables and store-data lanes, and sign/zero-extends load data. It delivers a registered writeback record to the writeback stage.

## Interface
- Parameters: none.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `valid_i` in 1: execute output valid.
- `ready_o` out 1: stage can accept; high only in IDLE.
- `alu_res_i` in 32: address (load/store) or result (other ops).
- `rs2_i` in 32: store data.
- `funct3_i` in 3: bits [1:0] select size (00 byte, 01 half, 1x word); bit 2 selects unsigned load.
- `load_i` in 1: load op.
- `store_i` in 1: store op; wins if both are set.
- `rd_i` in 5: destination register.
- `wb_en_i` in 1: register write enable.
- `valid_o` out 1: one-cycle pulse, writeback record valid.
- `rd_o` out 5, `wb_en_o` out 1, `wb_data_o` out 32: writeback record, registered.
- `misalign_o` out 1: misaligned access flag (LSU_MISALIGN_TRAP_EN only).
- `dmem_req_o` out 1, `dmem_we_o` out 1, `dmem_be_o` out 4, `dmem_addr_o` out 32, `dmem_wdata_o` out 32: request, registered.
- `dmem_gnt_i` in 1, `dmem_rvalid_i` in 1, `dmem_rdata_i` in 32: memory responses.

## Operation
- FSM states: IDLE, REQ, WAIT.
- Accept: `valid_i && ready_o`.
- Non-memory op:
  - Stays in IDLE.
  - Next cycle: `valid_o`=1, `wb_data_o`=`alu_res_i`, `rd_o`/`wb_en_o` copied.
- Memory op transitions:
  - IDLE→REQ on accept; request fields are latched.
  - REQ→WAIT on `dmem_gnt_i` for a load.
  - REQ→IDLE on `dmem_gnt_i` for a store, with `valid_o`=1 and `wb_en_o`=0 the next cycle.
  - WAIT→IDLE on `dmem_rvalid_i`; the extracted load data is registered and `valid_o`=1 the next cycle.
- `dmem_addr_o` = {addr[31:2], 2'b00}.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1], 1'b0}
  - word: 4'b1111
- Store data is replicated across lanes: byte {4{rs2[7:0]}}, half {2{rs2[15:0]}}, word rs2.
- Load extraction: shift `dmem_rdata_i` right by addr[1:0]×8, then sign-extend, or zero-extend when funct3[2]=1.
- No downstream backpressure: writeback always accepts.
- Edge cases:
  - `dmem_rvalid_i` is ignored outside WAIT.
  - `dmem_gnt_i` is ignored outside REQ.
  - Reset in REQ/WAIT abandons the transaction: `dmem_req_o` drops the next edge and no `valid_o` is produced.

## Timing
- Reset values:
  - state IDLE
  - `valid_o`, `dmem_req_o`, `dmem_we_o` = 0
  - `dmem_be_o`, `dmem_addr_o`, `dmem_wdata_o`, `wb_data_o`, `rd_o`, `wb_en_o`, `misalign_o` = 0
- `ready_o` is combinational: `ready_o` = (state==IDLE).
- Non-memory latency: accept at cycle N → `valid_o` at N+1.
- Request launch: accept at N → `dmem_req_o` high from N+1.
- While `dmem_req_o` is high, all `dmem_*_o` outputs are held stable until the `dmem_gnt_i` cycle G inclusive; `dmem_req_o` is low at G+1.
- Store completion: `valid_o` at G+1.
- Load completion: rvalid no earlier than G+1; rvalid at cycle R → `valid_o` at R+1.
- Minimum load latency: 3 cycles from accept.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- With the macro, misaligned accesses are trapped:
  - Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - No memory request is issued; FSM stays in IDLE.
  - Next cycle: `valid_o`=1, `misalign_o`=1, `wb_en_o`=0.
- Without the macro:
  - `misalign_o` port is absent.
  - Offending low address bits are forced to zero (half: addr[0]; word: addr[1:0]) and the access proceeds aligned.

## Structure
- Package `bamboo_pkg` holds:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`
  - `lsu_state_t` enum (IDLE, REQ, WAIT)
- One combinational sub-module, `lsu_align`:
  - inputs: addr[1:0], size, unsigned flag, rs2, rdata
  - outputs: be, replicated wdata, extended load data
- FSM and registers stay in `mem_access`.

## Test plan
- Pass-through: accept `alu_res_i`=0x1234_5678, rd=5, wb_en=1 → next cycle `valid_o`=1, `wb_data_o`=0x1234_5678, `rd_o`=5, `dmem_req_o` never high.
- SB at addr 0x1003 with rs2=0x0000_00AB, `dmem_gnt_i` delayed 2 cycles → addr 0x1000, be 4'b1000, wdata 0xABAB_ABAB held stable through the grant cycle; `valid_o`=1 with `wb_en_o`=0 one cycle after the grant.
- LB at addr 0x2001 with rdata 0x0000_8000 → `wb_data_o`=0xFFFF_FF80; LBU at the same address → 0x0000_0080; `valid_o` one cycle after rvalid.
- LH at addr 0x2002 with rdata 0x8001_0000 → `wb_data_o`=0xFFFF_8001, be 4'b1100; LHU at the same address → 0x0000_8001.
- LW at addr 0x3002, with macro → no request; next cycle `misalign_o`=1, `wb_en_o`=0. Without macro → request addr 0x3000, be 4'b1111.
- `rst` asserted in WAIT → `dmem_req_o`=0 and `ready_o`=1 the next cycle; a stray `dmem_rvalid_i` afterwards produces no `valid_o`.

Source files
------------

// File: rtl/bamboo_pkg.sv
// Shared types for the BamBoo load/store path: access-size codes and LSU FSM states.
package bamboo_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10
   } lsu_state_t;

   // funct3[1] set means word regardless of funct3[0]
   function automatic logic [1:0] size_of(input logic [2:0] f3);
      if (f3[1])
         return SZ_WORD;
      else if (f3[0])
         return SZ_HALF;
      else
         return SZ_BYTE;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables, store-data replication and load extraction/extension.
module lsu_align
   import bamboo_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  size_i,
   input  logic        uns_i,
   input  logic [31:0] rs2_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] ldata_o
);

   logic [31:0] w_shifted;

   assign w_shifted = rdata_i >> {addr_lo_i, 3'b000};

   always_comb begin
      be_o    = 4'b1111;
      wdata_o = rs2_i;
      ldata_o = w_shifted;
      case (size_i)
         SZ_BYTE: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{rs2_i[7:0]}};
            ldata_o = uns_i ? {24'h0, w_shifted[7:0]}
                            : {{24{w_shifted[7]}}, w_shifted[7:0]};
         end
         SZ_HALF: begin
            be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
            wdata_o = {2{rs2_i[15:0]}};
            ldata_o = uns_i ? {16'h0, w_shifted[15:0]}
                            : {{16{w_shifted[15]}}, w_shifted[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// RV32I memory-access stage: single-outstanding req/gnt/rvalid LSU plus registered writeback record.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of aligning them.
module mem_access
   import bamboo_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [31:0] alu_res_i,
   input  logic [31:0] rs2_i,
   input  logic [2:0]  funct3_i,
   input  logic        load_i,
   input  logic        store_i,
   input  logic [4:0]  rd_i,
   input  logic        wb_en_i,
   output logic        valid_o,
   output logic [4:0]  rd_o,
   output logic        wb_en_o,
   output logic [31:0] wb_data_o,
`ifdef LSU_MISALIGN_TRAP_EN
   output logic        misalign_o,
`endif
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i
);

   lsu_state_t  r_state;
   logic [1:0]  r_lo;
   logic [1:0]  r_size;
   logic        r_uns;
   logic        r_wb_en;

   logic        w_accept;
   logic        w_mem;
   logic        w_trap;
   logic [1:0]  w_size_in;
   logic [1:0]  w_lo_in;
   logic [1:0]  w_sel_lo;
   logic [1:0]  w_sel_size;
   logic        w_sel_uns;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_ldata;

   assign ready_o   = (r_state == IDLE);
   assign w_accept  = valid_i && ready_o;
   assign w_mem     = load_i || store_i;
   assign w_size_in = size_of(funct3_i);

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_lo_in = alu_res_i[1:0];
   assign w_trap  = w_mem && (((w_size_in == SZ_HALF) && alu_res_i[0]) ||
                              ((w_size_in == SZ_WORD) && (alu_res_i[1:0] != 2'b00)));
`else
   // misaligned accesses silently proceed aligned
   assign w_lo_in = (w_size_in == SZ_WORD) ? 2'b00 :
                    (w_size_in == SZ_HALF) ? {alu_res_i[1], 1'b0} : alu_res_i[1:0];
   assign w_trap  = 1'b0;
`endif

   // one lane steerer: live inputs at accept, latched fields while the load is in flight
   assign w_sel_lo   = ready_o ? w_lo_in      : r_lo;
   assign w_sel_size = ready_o ? w_size_in    : r_size;
   assign w_sel_uns  = ready_o ? funct3_i[2]  : r_uns;

   lsu_align u_align (
      .addr_lo_i (w_sel_lo),
      .size_i    (w_sel_size),
      .uns_i     (w_sel_uns),
      .rs2_i     (rs2_i),
      .rdata_i   (dmem_rdata_i),
      .be_o      (w_be),
      .wdata_o   (w_wdata),
      .ldata_o   (w_ldata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_lo         <= 2'b00;
         r_size       <= SZ_BYTE;
         r_uns        <= 1'b0;
         r_wb_en      <= 1'b0;
         valid_o      <= 1'b0;
         rd_o         <= 5'd0;
         wb_en_o      <= 1'b0;
         wb_data_o    <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
         misalign_o   <= 1'b0;
`endif
         dmem_req_o   <= 1'b0;
         dmem_we_o    <= 1'b0;
         dmem_be_o    <= 4'h0;
         dmem_addr_o  <= 32'h0;
         dmem_wdata_o <= 32'h0;
      end else begin
         valid_o <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         misalign_o <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  rd_o <= rd_i;
                  if (w_mem && !w_trap) begin
                     r_state      <= REQ;
                     r_lo         <= w_lo_in;
                     r_size       <= w_size_in;
                     r_uns        <= funct3_i[2];
                     r_wb_en      <= wb_en_i;
                     dmem_req_o   <= 1'b1;
                     dmem_we_o    <= store_i;
                     dmem_be_o    <= w_be;
                     dmem_addr_o  <= {alu_res_i[31:2], 2'b00};
                     dmem_wdata_o <= w_wdata;
                  end else begin
                     valid_o   <= 1'b1;
                     wb_data_o <= alu_res_i;
                     wb_en_o   <= wb_en_i && !w_trap;
`ifdef LSU_MISALIGN_TRAP_EN
                     misalign_o <= w_trap;
`endif
                  end
               end
            end
            REQ: begin
               if (dmem_gnt_i) begin
                  dmem_req_o <= 1'b0;
                  if (dmem_we_o) begin
                     r_state <= IDLE;
                     valid_o <= 1'b1;
                     wb_en_o <= 1'b0;
                  end else begin
                     r_state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (dmem_rvalid_i) begin
                  r_state   <= IDLE;
                  valid_o   <= 1'b1;
                  wb_data_o <= w_ldata;
                  wb_en_o   <= r_wb_en;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access against an arithmetic reference of the load/store rules.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] alu_res_i;
   logic [31:0] rs2_i;
   logic [2:0]  funct3_i;
   logic        load_i;
   logic        store_i;
   logic [4:0]  rd_i;
   logic        wb_en_i;
   logic        valid_o;
   logic [4:0]  rd_o;
   logic        wb_en_o;
   logic [31:0] wb_data_o;
`ifdef LSU_MISALIGN_TRAP_EN
   logic        misalign_o;
`endif
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_gnt_i;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_access dut (
      .clk           (clk),
      .rst           (rst),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .alu_res_i     (alu_res_i),
      .rs2_i         (rs2_i),
      .funct3_i      (funct3_i),
      .load_i        (load_i),
      .store_i       (store_i),
      .rd_i          (rd_i),
      .wb_en_i       (wb_en_i),
      .valid_o       (valid_o),
      .rd_o          (rd_o),
      .wb_en_o       (wb_en_o),
      .wb_data_o     (wb_data_o),
`ifdef LSU_MISALIGN_TRAP_EN
      .misalign_o    (misalign_o),
`endif
      .dmem_req_o    (dmem_req_o),
      .dmem_we_o     (dmem_we_o),
      .dmem_be_o     (dmem_be_o),
      .dmem_addr_o   (dmem_addr_o),
      .dmem_wdata_o  (dmem_wdata_o),
      .dmem_gnt_i    (dmem_gnt_i),
      .dmem_rvalid_i (dmem_rvalid_i),
      .dmem_rdata_i  (dmem_rdata_i)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic scramble_inputs;
      alu_res_i = $urandom;
      rs2_i     = $urandom;
      funct3_i  = 3'($urandom);
      load_i    = 1'($urandom);
      store_i   = 1'($urandom);
      rd_i      = 5'($urandom);
      wb_en_i   = 1'($urandom);
   endtask

   task automatic chk_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd);
      chk({tag, "_req"},   32'(dmem_req_o), 32'd1);
      chk({tag, "_we"},    32'(dmem_we_o), 32'(we));
      chk({tag, "_addr"},  dmem_addr_o, addr);
      chk({tag, "_be"},    32'(dmem_be_o), 32'(be));
      if (we)
         chk({tag, "_wdata"}, dmem_wdata_o, wd);
      chk({tag, "_nvalid"}, 32'(valid_o), 32'd0);
   endtask

   // one full transaction; starts and ends at a negedge with the stage idle
   task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d2, input logic [4:0] rd,
                        input logic we, input int gdel, input int rdel, input logic [31:0] rdata);
      int          nbytes;
      int          off;
      logic        is_mem;
      logic        trap;
      logic [3:0]  e_be;
      logic [31:0] e_addr;
      logic [31:0] e_wd;
      logic [31:0] v;
      is_mem = ld || st;
      nbytes = f3[1] ? 4 : (f3[0] ? 2 : 1);
      off    = int'(a[1:0]);
      trap   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      trap = is_mem && (off % nbytes != 0);
`else
      off = off - (off % nbytes);
`endif
      e_addr = a - (a % 4);
      e_be   = 4'(((1 << nbytes) - 1) << off);
      e_wd   = (nbytes == 1) ? d2[7:0] * 32'h0101_0101 :
               (nbytes == 2) ? d2[15:0] * 32'h0001_0001 : d2;

      chk("ready_before", 32'(ready_o), 32'd1);
      valid_i = 1'b1; load_i = ld; store_i = st; funct3_i = f3;
      alu_res_i = a; rs2_i = d2; rd_i = rd; wb_en_i = we;
      cyc();
      valid_i = 1'b0;
      scramble_inputs();

      if (!is_mem || trap) begin
         chk("pt_valid", 32'(valid_o), 32'd1);
         chk("pt_rd", 32'(rd_o), 32'(rd));
         chk("pt_wben", 32'(wb_en_o), 32'(we && !trap));
         chk("pt_noreq", 32'(dmem_req_o), 32'd0);
         if (!trap)
            chk("pt_data", wb_data_o, a);
`ifdef LSU_MISALIGN_TRAP_EN
         chk("pt_misalign", 32'(misalign_o), 32'(trap));
`endif
         return;
      end

      chk_req("launch", st, e_addr, e_be, e_wd);
      chk("ready_busy", 32'(ready_o), 32'd0);
      for (int i = 0; i < gdel; i++) begin
         dmem_rvalid_i = 1'($urandom);
         dmem_rdata_i  = $urandom;
         cyc();
         chk_req("hold", st, e_addr, e_be, e_wd);
      end
      dmem_rvalid_i = 1'b0;
      dmem_gnt_i    = 1'b1;
      cyc();
      dmem_gnt_i = 1'b0;
      chk("req_drop", 32'(dmem_req_o), 32'd0);

      if (st) begin
         chk("st_valid", 32'(valid_o), 32'd1);
         chk("st_wben", 32'(wb_en_o), 32'd0);
         chk("st_rd", 32'(rd_o), 32'(rd));
         chk("st_ready", 32'(ready_o), 32'd1);
         return;
      end

      chk("ld_wait_nvalid", 32'(valid_o), 32'd0);
      for (int i = 0; i < rdel; i++) begin
         dmem_gnt_i   = 1'($urandom);
         dmem_rdata_i = $urandom;
         cyc();
         chk("ld_wait_nvalid", 32'(valid_o), 32'd0);
         chk("ld_wait_noreq", 32'(dmem_req_o), 32'd0);
      end
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = rdata;
      cyc();
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = $urandom;

      v = rdata >> (8 * off);
      if (nbytes == 1) begin
         v = v % 256;
         if (!f3[2] && v >= 128) v = v - 256;
      end else if (nbytes == 2) begin
         v = v % 65536;
         if (!f3[2] && v >= 32768) v = v - 65536;
      end
      chk("ld_valid", 32'(valid_o), 32'd1);
      chk("ld_data", wb_data_o, v);
      chk("ld_rd", 32'(rd_o), 32'(rd));
      chk("ld_wben", 32'(wb_en_o), 32'(we));
      chk("ld_ready", 32'(ready_o), 32'd1);
   endtask

   // stray handshake strobes while idle must not produce anything
   task automatic idle_stray;
      dmem_gnt_i    = 1'($urandom);
      dmem_rvalid_i = 1'($urandom);
      dmem_rdata_i  = $urandom;
      cyc();
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      chk("idle_nvalid", 32'(valid_o), 32'd0);
      chk("idle_noreq", 32'(dmem_req_o), 32'd0);
   endtask

   initial begin
      rst = 1'b1; valid_i = 1'b0;
      alu_res_i = '0; rs2_i = '0; funct3_i = '0; load_i = 1'b0; store_i = 1'b0;
      rd_i = '0; wb_en_i = 1'b0;
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
      @(negedge clk);
      cyc();
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_req", 32'(dmem_req_o), 32'd0);
      chk("rst_we", 32'(dmem_we_o), 32'd0);
      chk("rst_be", 32'(dmem_be_o), 32'd0);
      chk("rst_addr", dmem_addr_o, 32'd0);
      chk("rst_wdata", dmem_wdata_o, 32'd0);
      chk("rst_wbdata", wb_data_o, 32'd0);
      chk("rst_rd", 32'(rd_o), 32'd0);
      chk("rst_wben", 32'(wb_en_o), 32'd0);
      chk("rst_ready", 32'(ready_o), 32'd1);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("rst_misalign", 32'(misalign_o), 32'd0);
`endif
      rst = 1'b0;
      cyc();

      // directed cases
      do_op(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd5, 1'b1, 0, 0, 32'h0);
      chk("dir_pt_data", wb_data_o, 32'h1234_5678);
      do_op(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 5'd1, 1'b1, 2, 0, 32'h0);
      do_op(1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'h0, 5'd7, 1'b1, 0, 0, 32'h0000_8000);
      chk("dir_lb", wb_data_o, 32'hFFFF_FF80);
      do_op(1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'h0, 5'd7, 1'b1, 1, 2, 32'h0000_8000);
      chk("dir_lbu", wb_data_o, 32'h0000_0080);
      do_op(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 5'd8, 1'b1, 0, 1, 32'h8001_0000);
      chk("dir_lh", wb_data_o, 32'hFFFF_8001);
      do_op(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 5'd8, 1'b1, 0, 0, 32'h8001_0000);
      chk("dir_lhu", wb_data_o, 32'h0000_8001);
      do_op(1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0, 5'd9, 1'b1, 0, 0, 32'hCAFE_F00D);
      do_op(1'b1, 1'b1, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 5'd3, 1'b1, 1, 0, 32'h0);

      // reset during REQ abandons the request
      valid_i = 1'b1; load_i = 1'b1; store_i = 1'b0; funct3_i = 3'b010;
      alu_res_i = 32'h0000_5000; rd_i = 5'd4; wb_en_i = 1'b1;
      cyc();
      valid_i = 1'b0;
      chk("rreq_req", 32'(dmem_req_o), 32'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rreq_req0", 32'(dmem_req_o), 32'd0);
      chk("rreq_ready", 32'(ready_o), 32'd1);
      dmem_gnt_i = 1'b1;
      cyc();
      dmem_gnt_i = 1'b0;
      chk("rreq_gnt_nvalid", 32'(valid_o), 32'd0);
      chk("rreq_gnt_noreq", 32'(dmem_req_o), 32'd0);

      // reset during WAIT; a later stray rvalid must be ignored
      valid_i = 1'b1;
      cyc();
      valid_i = 1'b0;
      dmem_gnt_i = 1'b1;
      cyc();
      dmem_gnt_i = 1'b0;
      chk("rwait_busy", 32'(ready_o), 32'd0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rwait_req0", 32'(dmem_req_o), 32'd0);
      chk("rwait_ready", 32'(ready_o), 32'd1);
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = 32'h1111_2222;
      cyc();
      dmem_rvalid_i = 1'b0;
      chk("rwait_stray_nvalid", 32'(valid_o), 32'd0);
      cyc();
      chk("rwait_stray_nvalid2", 32'(valid_o), 32'd0);

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         int kind;
         kind = int'($urandom_range(0, 3));
         do_op(kind == 1 || kind == 3, kind == 2 || kind == 3, 3'($urandom), $urandom,
               $urandom, 5'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), $urandom);
         idle_stray();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
